// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared definitions for the BCD stopwatch controller: FSM encoding and digit limits.
package bcd_stopwatch_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVF   = 2'd3;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE,
        S_OVF   = ST_OVF
    } sw_state_e;

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command, status and lap-readout signals between the stopwatch controller and its users.
interface bcd_stopwatch_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  cmd_start;
    logic                  cmd_stop;
    logic                  cmd_clear;
    logic                  cmd_lap;
    logic                  lap_ack;
    logic                  running;
    logic                  tick;
    logic [4*DIGITS-1:0]   digits;
    logic                  overflow;
    logic                  lap_valid;
    logic [4*DIGITS-1:0]   lap_data;

    modport master (
        output cmd_start, cmd_stop, cmd_clear, cmd_lap, lap_ack,
        input  running, tick, digits, overflow, lap_valid, lap_data
    );

    modport slave (
        input  cmd_start, cmd_stop, cmd_clear, cmd_lap, lap_ack,
        output running, tick, digits, overflow, lap_valid, lap_data
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl_digit_en.sv
// One decade (0-9) counter stage with enable, synchronous clear and terminal flag.
module bcd_digit_en
    import bcd_stopwatch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       at_max
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (en) begin
            q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q      = q_q;
    assign at_max = (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer: start/stop/clear FSM, tick prescaler, cascaded BCD digits, lap register.
module bcd_stopwatch_ctrl
    import bcd_stopwatch_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int PS_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_stopwatch_ctrl_if.slave  sw
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    sw_state_e            state_q, state_d;
    logic [PS_W-1:0]      pscnt_q, pscnt_d;
    logic                 lap_valid_q, lap_valid_d;
    logic [4*DIGITS-1:0]  lap_data_q, lap_data_d;
    logic [4*DIGITS-1:0]  digits_w;
    logic [DIGITS-1:0]    at_max;
    logic [DIGITS-1:0]    lower_max;
    logic                 ps_wrap;
    logic                 tick_w;
    logic                 saturate;
    logic                 count_en;
    logic                 capture;

    assign ps_wrap  = (pscnt_q == PS_LAST);
    assign tick_w   = (state_q == S_RUN) && ps_wrap && !sw.cmd_clear && !sw.cmd_stop;
    assign saturate = &at_max;
    // At 9..9 the tick still fires but the chain must hold instead of wrapping.
    assign count_en = tick_w && !saturate;
    assign capture  = sw.cmd_lap && ((state_q == S_RUN) || (state_q == S_PAUSE));

    always_comb begin
        state_d = state_q;
        pscnt_d = pscnt_q;
        if (sw.cmd_clear) begin
            state_d = S_IDLE;
            pscnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sw.cmd_start && !sw.cmd_stop) begin
                        state_d = S_RUN;
                        pscnt_d = '0;
                    end
                end
                S_RUN: begin
                    if (sw.cmd_stop) begin
                        state_d = S_PAUSE;
                    end else begin
                        pscnt_d = ps_wrap ? '0 : pscnt_q + PS_W'(1);
                        if (tick_w && saturate) begin
                            state_d = S_OVF;
                        end
                    end
                end
                S_PAUSE: begin
                    if (sw.cmd_start && !sw.cmd_stop) begin
                        state_d = S_RUN;
                    end
                end
                S_OVF:   state_d = S_OVF;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        lap_data_d  = lap_data_q;
        lap_valid_d = lap_valid_q;
        if (capture) begin
            lap_data_d  = digits_w;
            lap_valid_d = 1'b1;
        end else if (sw.lap_ack) begin
            lap_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pscnt_q     <= '0;
            lap_valid_q <= 1'b0;
            lap_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pscnt_q     <= pscnt_d;
            lap_valid_q <= lap_valid_d;
            lap_data_q  <= lap_data_d;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_lsd
            assign lower_max[k] = 1'b1;
        end else begin : g_upper
            assign lower_max[k] = &at_max[k-1:0];
        end

        bcd_digit_en u_digit (
            .clk    (clk),
            .rst    (rst),
            .en     (count_en && lower_max[k]),
            .clr    (sw.cmd_clear),
            .q      (digits_w[4*k +: 4]),
            .at_max (at_max[k])
        );
    end

    assign sw.running   = (state_q == S_RUN);
    assign sw.overflow  = (state_q == S_OVF);
    assign sw.tick      = tick_w;
    assign sw.digits    = digits_w;
    assign sw.lap_valid = lap_valid_q;
    assign sw.lap_data  = lap_data_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench for bcd_stopwatch_ctrl with DIGITS=2, PRESCALE=4.
module tb_bcd_stopwatch_ctrl;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;
    localparam int PS_W     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_stopwatch_ctrl_if #(.DIGITS(DIGITS)) sw();

    bcd_stopwatch_ctrl #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw)
    );

    always #5 clk = ~clk;

    typedef enum {O_RUN, O_TICK, O_DIG, O_OVF, O_LV, O_LD} obs_e;
    typedef struct {
        string       tag;
        obs_e        sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   tick_obs[$];
    int   tick_exp[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc   = 0;
    int   m_cnt = 0;
    int   c0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (rst && sw.tick) tick_obs.push_back(cyc);

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] obs(input obs_e s);
        case (s)
            O_RUN:   return {31'd0, sw.running};
            O_TICK:  return {31'd0, sw.tick};
            O_DIG:   return 32'(sw.digits);
            O_OVF:   return {31'd0, sw.overflow};
            O_LV:    return {31'd0, sw.lap_valid};
            default: return 32'(sw.lap_data);
        endcase
    endfunction

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic expect_o(input string tag, input obs_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk_val(e.tag, obs(e.sig), e.val);
        end
    endtask

    task automatic tick_drain(input string tag);
        int n;
        chk_val({tag, "_count"}, 32'(tick_obs.size()), 32'(tick_exp.size()));
        n = (tick_obs.size() < tick_exp.size()) ? tick_obs.size() : tick_exp.size();
        for (int i = 0; i < n; i++) begin
            chk_val({tag, "_cycle"}, 32'(tick_obs[i]), 32'(tick_exp[i]));
        end
        tick_obs.delete();
        tick_exp.delete();
    endtask

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmd(input bit st, input bit sp, input bit cl, input bit lp, input bit ak);
        sw.cmd_start = st;
        sw.cmd_stop  = sp;
        sw.cmd_clear = cl;
        sw.cmd_lap   = lp;
        sw.lap_ack   = ak;
        edges(1);
        sw.cmd_start = 1'b0;
        sw.cmd_stop  = 1'b0;
        sw.cmd_clear = 1'b0;
        sw.cmd_lap   = 1'b0;
        sw.lap_ack   = 1'b0;
    endtask

    task automatic expect_reset_vals(input string tag);
        expect_o({tag, "_running"},  O_RUN,  32'd0);
        expect_o({tag, "_tick"},     O_TICK, 32'd0);
        expect_o({tag, "_digits"},   O_DIG,  32'd0);
        expect_o({tag, "_overflow"}, O_OVF,  32'd0);
        expect_o({tag, "_lapv"},     O_LV,   32'd0);
        expect_o({tag, "_lapd"},     O_LD,   32'd0);
        sb_drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sw.cmd_start = 1'b0;
        sw.cmd_stop  = 1'b0;
        sw.cmd_clear = 1'b0;
        sw.cmd_lap   = 1'b0;
        sw.lap_ack   = 1'b0;
        #1 rst = 1'b0;
        #1;
        expect_reset_vals("rst");
        #1 rst = 1'b1;
        edges(1);

        // Start, then ticks every PRESCALE cycles.
        cmd(1, 0, 0, 0, 0);
        c0 = cyc;
        tick_obs.delete();
        for (int i = 0; i < 3; i++) tick_exp.push_back(c0 + 3 + 4*i);
        expect_o("t1_running", O_RUN, 32'd1);
        sb_drain();
        for (int i = 0; i < 3; i++) begin
            edges(PRESCALE);
            m_cnt++;
            expect_o("t1_digits", O_DIG, to_bcd(m_cnt));
            sb_drain();
        end
        tick_drain("t1_tick");

        // Carry from digit 0 into digit 1.
        edges(6*PRESCALE);
        m_cnt = 9;
        expect_o("t2_digits09", O_DIG, to_bcd(m_cnt));
        sb_drain();
        edges(PRESCALE);
        m_cnt = 10;
        expect_o("t2_digits10", O_DIG, to_bcd(m_cnt));
        sb_drain();

        // Pause with pscnt=2, resume: one more cycle to the tick.
        edges(2);
        cmd(0, 1, 0, 0, 0);
        expect_o("t3_paused", O_RUN, 32'd0);
        sb_drain();
        edges(3);
        expect_o("t3_frozen", O_DIG, to_bcd(m_cnt));
        sb_drain();
        tick_obs.delete();
        cmd(1, 0, 0, 0, 0);
        tick_exp.push_back(cyc + 1);
        expect_o("t3_resumed", O_RUN, 32'd1);
        sb_drain();
        edges(2);
        tick_drain("t3_tick");
        m_cnt = 11;
        expect_o("t3_digits", O_DIG, to_bcd(m_cnt));
        sb_drain();

        // Saturation at 99.
        edges(88*PRESCALE);
        m_cnt = 99;
        expect_o("t4_digits99", O_DIG, to_bcd(m_cnt));
        expect_o("t4_pre_ovf", O_OVF, 32'd0);
        sb_drain();
        edges(PRESCALE);
        expect_o("t4_sat_digits", O_DIG, to_bcd(99));
        expect_o("t4_overflow", O_OVF, 32'd1);
        expect_o("t4_running", O_RUN, 32'd0);
        sb_drain();
        cmd(1, 0, 0, 0, 0);
        expect_o("t4_start_ign", O_OVF, 32'd1);
        expect_o("t4_start_run", O_RUN, 32'd0);
        sb_drain();
        cmd(0, 1, 0, 0, 0);
        expect_o("t4_stop_ign", O_OVF, 32'd1);
        sb_drain();
        cmd(0, 0, 0, 1, 0);
        expect_o("t4_lap_ign", O_LV, 32'd0);
        sb_drain();
        edges(PRESCALE);
        expect_o("t4_hold99", O_DIG, to_bcd(99));
        sb_drain();
        cmd(0, 0, 1, 0, 0);
        m_cnt = 0;
        expect_o("t4_clr_digits", O_DIG, 32'd0);
        expect_o("t4_clr_ovf", O_OVF, 32'd0);
        expect_o("t4_clr_run", O_RUN, 32'd0);
        sb_drain();

        // Lap capture, overwrite, acknowledge, capture on a tick edge.
        cmd(1, 0, 0, 0, 0);
        edges(5*PRESCALE);
        m_cnt = 5;
        expect_o("t5_digits05", O_DIG, to_bcd(m_cnt));
        sb_drain();
        cmd(0, 0, 0, 1, 0);
        expect_o("t5_lapv", O_LV, 32'd1);
        expect_o("t5_lapd05", O_LD, to_bcd(5));
        sb_drain();
        edges(3 + PRESCALE);
        m_cnt = 7;
        expect_o("t5_digits07", O_DIG, to_bcd(m_cnt));
        sb_drain();
        cmd(0, 0, 0, 1, 0);
        expect_o("t5_lapv2", O_LV, 32'd1);
        expect_o("t5_lapd07", O_LD, to_bcd(7));
        sb_drain();
        cmd(0, 0, 0, 0, 1);
        expect_o("t5_ack", O_LV, 32'd0);
        sb_drain();
        edges(1);
        expect_o("t5_tick_high", O_TICK, 32'd1);
        sb_drain();
        cmd(0, 0, 0, 1, 1);
        m_cnt = 8;
        expect_o("t5_lap_ack_lv", O_LV, 32'd1);
        expect_o("t5_lap_pre_inc", O_LD, to_bcd(7));
        expect_o("t5_digits08", O_DIG, to_bcd(m_cnt));
        sb_drain();

        // clear > stop > start; clear leaves the lap register alone.
        cmd(1, 1, 1, 0, 0);
        expect_o("t6_run", O_RUN, 32'd0);
        expect_o("t6_digits", O_DIG, 32'd0);
        expect_o("t6_ovf", O_OVF, 32'd0);
        expect_o("t6_lapv", O_LV, 32'd1);
        expect_o("t6_lapd", O_LD, to_bcd(7));
        sb_drain();
        cmd(1, 0, 0, 0, 0);
        edges(PRESCALE + 1);
        expect_o("t6_digits01", O_DIG, to_bcd(1));
        sb_drain();
        #2 rst = 1'b0;
        #1;
        expect_reset_vals("t6_async_rst");
        #2 rst = 1'b1;
        edges(2);
        expect_o("t6_post_rst_idle", O_RUN, 32'd0);
        expect_o("t6_post_rst_digits", O_DIG, 32'd0);
        sb_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
